// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load unit (B).
// Optional WB_ZERO_DROP_EN: accepted writes to register 0 are dropped (hardwired-zero r0).
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module regfile_wb_arbiter #(
    parameter int ASIZE = `ASIZE,
    parameter int DSIZE = `DSIZE,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             a_valid,
    input  logic [ASIZE-1:0] a_addr,
    input  logic [DSIZE-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [ASIZE-1:0] b_addr,
    input  logic [DSIZE-1:0] b_data,
    output logic             b_ready,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] wdata,
    output logic [CNTW-1:0]  conflicts
);

    logic             last_b;
    logic             grant_a;
    logic             grant_b;
    logic             write;
    logic             conflict;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_data;

    always_comb begin
        conflict = a_valid & b_valid & ~hold;
        // On conflict the source that did not win last time goes first.
        grant_a  = ~rst & ~hold & a_valid & (~b_valid | last_b);
        grant_b  = ~rst & ~hold & b_valid & (~a_valid | ~last_b);
        sel_addr = grant_b ? b_addr : a_addr;
        sel_data = grant_b ? b_data : a_data;
`ifdef WB_ZERO_DROP_EN
        write    = (grant_a | grant_b) & (sel_addr != '0);
`else
        write    = grant_a | grant_b;
`endif
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            conflicts <= '0;
            last_b    <= 1'b0;
        end else begin
            wen <= write;
            if (write) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
            if (grant_b) begin
                last_b <= 1'b1;
            end else if (grant_a) begin
                last_b <= 1'b0;
            end
            if (conflict && (conflicts != {CNTW{1'b1}})) begin
                conflicts <= conflicts + 1'b1;
            end
        end
    end

endmodule
